rnd_hash_requester: RTL and testbench

- Initiator/consumer on the far side of the RND generator interface.
- Drives start_rnd and seed, waits for done_rnd, and captures the 2-bit RND symbol at each done.
- Packs HASH_WIDTH/2 successive symbols into one hash word, then presents it on a valid/ready output handshake to the hash datapath.

---
 rtl/rnd_hash_requester.sv | 187 ++++++++++++++++++
 tb/tb_rnd_hash_requester.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rnd_hash_requester.sv
// Requester on the far side of the RND generator: runs HASH_WIDTH/2 generator passes and packs the symbols into one hash word.
// Optional WAIT-state timeout is enabled with the RND_REQ_TIMEOUT_EN macro.
module rnd_hash_requester #(
    parameter int REG_WIDTH      = 6,
    parameter int HASH_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 32,
    parameter int TO_WIDTH       = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [REG_WIDTH-1:0]  base_seed,
    output logic                  busy,
    output logic                  hash_valid,
    input  logic                  hash_ready,
    output logic [HASH_WIDTH-1:0] hash_out,
    output logic                  start_rnd,
    output logic [REG_WIDTH-1:0]  seed,
    input  logic                  done_rnd,
    input  logic [1:0]            x_in,
    output logic                  err_timeout
);

    localparam int NSYM  = HASH_WIDTH / 2;
    localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSYM - 1);

    if ((HASH_WIDTH < 4) || ((HASH_WIDTH % 2) != 0)) begin : g_bad_hash_width
        $error("HASH_WIDTH must be even and at least 4");
    end
    if ((1 << TO_WIDTH) <= TIMEOUT_CYCLES) begin : g_bad_to_width
        $error("TO_WIDTH too narrow for TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [REG_WIDTH-1:0]  base_q, base_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [HASH_WIDTH-1:0] shift_q, shift_d;
    logic [REG_WIDTH-1:0]  seed_q, seed_d;
    logic [HASH_WIDTH-1:0] hash_out_q, hash_out_d;
    logic                  start_rnd_q, start_rnd_d;
    logic                  busy_q, busy_d;
    logic                  hash_valid_q, hash_valid_d;
    logic [HASH_WIDTH-1:0] cap_s;
    logic [IDX_W-1:0]      idx_inc_s;

`ifdef RND_REQ_TIMEOUT_EN
    logic [TO_WIDTH-1:0]   cnt_q, cnt_d;
    logic                  err_q, err_d;
`endif

    assign cap_s     = {shift_q[HASH_WIDTH-3:0], x_in};
    assign idx_inc_s = idx_q + IDX_W'(1);

    // Next-state and next-output computation; outputs are registered from the next state.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        seed_d     = seed_q;
        hash_out_d = hash_out_q;
`ifdef RND_REQ_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    base_d  = base_seed;
                    idx_d   = '0;
                    shift_d = '0;
                    seed_d  = base_seed;
                    state_d = S_START;
`ifdef RND_REQ_TIMEOUT_EN
                    err_d   = 1'b0;
                    cnt_d   = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                state_d = S_WAIT;
`ifdef RND_REQ_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                // A done on the expiry cycle takes priority over the timeout.
                if (done_rnd) begin
                    shift_d = cap_s;
                    if (idx_q == IDX_LAST) begin
                        hash_out_d = cap_s;
                        state_d    = S_DONE;
                    end else begin
                        idx_d   = idx_inc_s;
                        seed_d  = base_q ^ REG_WIDTH'(idx_inc_s);
                        state_d = S_START;
                    end
`ifdef RND_REQ_TIMEOUT_EN
                end else if (cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    shift_d = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + TO_WIDTH'(1);
                    state_d = S_WAIT;
                end
`else
                end else begin
                    state_d = S_WAIT;
                end
`endif
            end
            S_DONE: begin
                if (hash_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        start_rnd_d  = (state_d == S_START);
        busy_d       = (state_d != S_IDLE);
        hash_valid_d = (state_d == S_DONE);
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            seed_q       <= '0;
            hash_out_q   <= '0;
            start_rnd_q  <= 1'b0;
            busy_q       <= 1'b0;
            hash_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            seed_q       <= seed_d;
            hash_out_q   <= hash_out_d;
            start_rnd_q  <= start_rnd_d;
            busy_q       <= busy_d;
            hash_valid_q <= hash_valid_d;
        end
    end

`ifdef RND_REQ_TIMEOUT_EN
    // WAIT-cycle counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err_timeout = err_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign busy       = busy_q;
    assign hash_valid = hash_valid_q;
    assign hash_out   = hash_out_q;
    assign start_rnd  = start_rnd_q;
    assign seed       = seed_q;

endmodule

// File: tb/tb_rnd_hash_requester.sv
// Scoreboard bench for rnd_hash_requester: expected start pulses and hash words are queued at stimulus time
// and checked by an independent monitor; RND_REQ_TIMEOUT_EN adds the timeout scenarios.
module tb_rnd_hash_requester;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [5:0] base_seed = 6'h00;
    logic       hash_ready = 1'b1;
    logic       done_rnd = 1'b0;
    logic [1:0] x_in = 2'b00;
    logic       busy, hash_valid, start_rnd, err_timeout;
    logic [7:0] hash_out;
    logic [5:0] seed;

    rnd_hash_requester #(.REG_WIDTH(6), .HASH_WIDTH(8), .TIMEOUT_CYCLES(32), .TO_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .req(req), .base_seed(base_seed), .busy(busy),
        .hash_valid(hash_valid), .hash_ready(hash_ready), .hash_out(hash_out),
        .start_rnd(start_rnd), .seed(seed), .done_rnd(done_rnd), .x_in(x_in),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int t0 = 0;

    typedef struct packed { int c; logic [5:0] s; } st_t;
    typedef struct packed { int c; logic [7:0] v; } hs_t;
    st_t st_q[$];
    hs_t hq[$];

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // RND generator model: done one cycle, dly cycles after a start pulse, x_in = seed[1:0]
    int         dly = 3;
    bit         mute_en = 1'b0;
    logic [5:0] mute_seed = 6'h00;
    bit         inject = 1'b0;
    int         rcnt = 0;
    logic [5:0] rseed = 6'h00;
    always @(negedge clk) begin
        done_rnd = 1'b0;
        x_in     = 2'b00;
        if (rcnt != 0) begin
            rcnt--;
            if (rcnt == 0) begin
                done_rnd = 1'b1;
                x_in     = rseed[1:0];
            end
        end
        if (start_rnd && !(mute_en && seed == mute_seed)) begin
            rcnt  = dly;
            rseed = seed;
        end
        if (inject) begin
            done_rnd = 1'b1;
            x_in     = 2'b11;
        end
    end

    // Monitor: pop and compare on every start pulse and on each rising hash_valid
    bit hv_prev = 1'b0;
    always @(negedge clk) begin
        st_t es;
        hs_t eh;
        if (start_rnd === 1'b1) begin
            if (st_q.size() == 0) begin
                check("unexpected_start", 32'd1, 32'd0);
            end else begin
                es = st_q.pop_front();
                check("start_cycle", cyc, es.c);
                check("seed", {26'd0, seed}, {26'd0, es.s});
            end
        end
        if (hash_valid === 1'b1 && !hv_prev) begin
            if (hq.size() == 0) begin
                check("unexpected_hash_valid", 32'd1, 32'd0);
            end else begin
                eh = hq.pop_front();
                check("valid_cycle", cyc, eh.c);
                check("hash_out", {24'd0, hash_out}, {24'd0, eh.v});
            end
        end
        hv_prev = (hash_valid === 1'b1);
    end

    task automatic issue(input logic [5:0] b, input int nseed, input bit with_hash, input logic [7:0] hexp);
        @(negedge clk);
        req       = 1'b1;
        base_seed = b;
        t0        = cyc;
        for (int k = 0; k < nseed; k++) st_q.push_back('{c: t0 + 1 + k * (dly + 1), s: b ^ 6'(k)});
        if (with_hash) hq.push_back('{c: t0 + 1 + nseed * (dly + 1), v: hexp});
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_within_budget", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_hash_valid"}, {31'd0, hash_valid}, 32'd0);
        check({tag, "_start_rnd"}, {31'd0, start_rnd}, 32'd0);
        check({tag, "_seed"}, {26'd0, seed}, 32'd0);
        check({tag, "_hash_out"}, {24'd0, hash_out}, 32'd0);
        check({tag, "_err"}, {31'd0, err_timeout}, 32'd0);
    endtask

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Nominal run
        issue(6'h07, 4, 1'b1, 8'hE4);
        wait_idle(100);
        check("nominal_idle_cycle", cyc, t0 + 18);
        check("nominal_hash_retained", {24'd0, hash_out}, 32'hE4);
        check("nominal_err", {31'd0, err_timeout}, 32'd0);

        // Backpressure in DONE
        hash_ready = 1'b0;
        issue(6'h07, 4, 1'b1, 8'hE4);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (hash_valid === 1'b1);
        end
        check("bp_valid_seen", {31'd0, seen}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hash_valid_hold", {31'd0, hash_valid}, 32'd1);
            check("bp_hash_out_hold", {24'd0, hash_out}, 32'hE4);
            check("bp_busy_hold", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        check("bp_still_valid", {31'd0, hash_valid}, 32'd1);
        hash_ready = 1'b1;
        @(negedge clk);
        check("bp_valid_dropped", {31'd0, hash_valid}, 32'd0);
        check("bp_busy_dropped", {31'd0, busy}, 32'd0);
        check("bp_hash_retained", {24'd0, hash_out}, 32'hE4);

        // req during WAIT and done_rnd during IDLE are ignored
        issue(6'h07, 4, 1'b1, 8'hE4);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        wait_idle(100);
        @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        check("ign_busy", {31'd0, busy}, 32'd0);
        check("ign_start", {31'd0, start_rnd}, 32'd0);
        @(negedge clk);
        check("ign_busy2", {31'd0, busy}, 32'd0);
        check("ign_hash_out", {24'd0, hash_out}, 32'hE4);
        issue(6'h07, 4, 1'b1, 8'hE4);
        wait_idle(100);

        // Synchronous reset during the second WAIT
        issue(6'h07, 4, 1'b1, 8'hE4);
        wait_cyc(t0 + 6);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        st_q.delete();
        hq.delete();
        repeat (6) @(negedge clk);
        check("post_reset_idle", {31'd0, busy}, 32'd0);
        issue(6'h07, 4, 1'b1, 8'hE4);
        wait_idle(100);

`ifdef RND_REQ_TIMEOUT_EN
        // No done after the second start: timeout after 32 WAIT cycles
        mute_seed = 6'h06;
        mute_en   = 1'b1;
        issue(6'h07, 2, 1'b0, 8'h00);
        wait_cyc(t0 + 37);
        check("to_err_before", {31'd0, err_timeout}, 32'd0);
        check("to_busy_before", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("to_err_set", {31'd0, err_timeout}, 32'd1);
        check("to_busy_clear", {31'd0, busy}, 32'd0);
        check("to_no_valid", {31'd0, hash_valid}, 32'd0);
        mute_en = 1'b0;
        repeat (3) @(negedge clk);
        check("to_err_sticky", {31'd0, err_timeout}, 32'd1);
        issue(6'h07, 4, 1'b1, 8'hE4);
        check("to_err_cleared", {31'd0, err_timeout}, 32'd0);
        wait_idle(100);

        // done_rnd exactly on the expiry cycle wins
        dly = 32;
        issue(6'h07, 4, 1'b1, 8'hE4);
        wait_idle(300);
        check("expiry_err", {31'd0, err_timeout}, 32'd0);
        check("expiry_hash", {24'd0, hash_out}, 32'hE4);
        dly = 3;
`endif

        repeat (2) @(negedge clk);
        check("start_queue_empty", st_q.size(), 32'd0);
        check("hash_queue_empty", hq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
